mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-ported, pipelined main memory between the fetch-side line fill and the
//  memory-stage requester (data line fill or single-word write).
//  Sits between the I/D caches and main memory. Sequences multi-word line fills.
//  Raises per-side stall signals that feed the pipeline hazard/stall logic.
// PARAMETERS
//  ADDR_W      16  byte-address width
//  DATA_W      16  word width (word = 2 bytes)
//  MEM_LAT     4   cycles from read issue (mem_en & ~mem_wr) to mem_data_valid
//  LINE_WORDS  8   words per cache line (power of 2); IDX_W = log2(LINE_WORDS)
// PORTS
//  clk           in   1       system clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  i_req         in   1       fetch-side line fill request; level, held until i_done
//  i_addr        in   ADDR_W  fill address; low log2(LINE_WORDS*2) bits ignored
//  i_stall       out  1       i_req & ~i_done
//  i_fill_valid  out  1       i_fill_data valid this cycle
//  i_fill_data   out  DATA_W  returned word
//  i_fill_idx    out  IDX_W   word index within line
//  i_done        out  1       1-cycle pulse: fill complete
//  d_req         in   1       memory-stage request; level, held until d_done
//  d_we          in   1       1: single-word write; 0: line fill
//  d_addr        in   ADDR_W  write word address / fill address (aligned as i_addr)
//  d_wdata       in   DATA_W  write data
//  d_stall       out  1       d_req & ~d_done
//  d_fill_valid  out  1       d_fill_data valid
//  d_fill_data   out  DATA_W  returned word
//  d_fill_idx    out  IDX_W   word index within line
//  d_done        out  1       1-cycle pulse: write issued or fill complete
//  mem_en        out  1       memory access this cycle
//  mem_wr        out  1       1: write, 0: read (valid with mem_en)
//  mem_addr      out  ADDR_W  memory byte address
//  mem_wdata     out  DATA_W  write data
//  mem_data_valid in  1       read data returning
//  mem_rdata     in   DATA_W  read data
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; counters=0; latched addr/data=0.
//    All registered/decoded outputs=0. Stalls stay combinational from req (done=0).
//  - FSM states: IDLE, I_FILL, D_FILL, D_WRITE.
//  - IDLE grants on the clock edge:
//    d_req&d_we -> D_WRITE; d_req&~d_we -> D_FILL; else i_req -> I_FILL.
//    Data side has fixed priority. There is no preemption.
//  - Grant latches base=addr & ~(LINE_WORDS*2-1); D_WRITE latches d_addr and d_wdata.
//    Requester inputs are don't-care after grant.
//  - D_WRITE (1 cycle): mem_en=1, mem_wr=1, mem_addr/mem_wdata=latched values.
//    d_done=1 in the same cycle, then -> IDLE.
//  - FILL issue: mem_en=1, mem_wr=0 for LINE_WORDS consecutive cycles,
//    mem_addr=base+2*issue_cnt, issue_cnt 0..LINE_WORDS-1.
//  - FILL receive: each mem_data_valid routes mem_rdata to the owner's fill_data.
//    Owner fill_valid=1, fill_idx=recv_cnt, then recv_cnt++.
//    The non-owner fill_valid stays 0.
//  - Fill completes on the last word (recv_cnt==LINE_WORDS-1): owner done=1 that cycle.
//    Next state is IDLE, so at least 1 IDLE cycle separates grants.
//  - Latency with defaults: grant at T0; issue T1..T8; data T5..T12; done T12; IDLE T13.
//    Fill takes LINE_WORDS+MEM_LAT cycles after grant.
//  - Req deasserted mid-operation: ignored; the operation completes and done still pulses.
//  - mem_data_valid in IDLE or D_WRITE: ignored, counters unchanged.
//  - Simultaneous i_req and d_req: D serviced first. I is granted in the IDLE cycle after d_done.
//  - Address arithmetic is ADDR_W-bit. Line bases are aligned, so base+2*idx never wraps.
//  - Reset mid-fill: FSM aborts to IDLE immediately, with no done pulse.
//    Main memory shares rst_n and discards in-flight reads.
// TESTING
//  - Reset: rst_n=0 mid-I_FILL -> all outputs 0 asynchronously.
//    After release, first fill counts words from idx 0.
//  - I fill alone: i_req, i_addr=0x1237 -> mem_addr 0x1230..0x123E on T1..T8, mem_wr=0.
//    Data returns with idx 0..7 on T5..T12; i_done T12; i_stall falls T12.
//  - D write: d_req, d_we=1, d_addr=0x0040, d_wdata=0xBEEF -> T1: mem_en=1, mem_wr=1,
//    mem_addr=0x0040, mem_wdata=0xBEEF, d_done=1.
//  - Contention: i_req+d_req(fill) at T0 -> D_FILL first; d_done T12; IDLE T13.
//    I_FILL T14, first mem_addr at T14; i_stall held high throughout.
//  - Top line: d fill at 0xFFF8 -> addresses 0xFFF0..0xFFFE, no wrap past 0xFFFE.
//  - Robustness: drop i_req at T3 -> fill completes, i_done T12.
//    Stray mem_data_valid in IDLE -> no fill_valid pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port main memory arbiter for I/D line fills and D writes
// Data side has fixed priority; fills issue LINE_WORDS reads and route returns to the owner.
module mem_arbiter #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned MEM_LAT    = 4,
   parameter int unsigned LINE_WORDS = 8,
   localparam int unsigned IDX_W     = $clog2(LINE_WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_stall,
   output logic              i_fill_valid,
   output logic [DATA_W-1:0] i_fill_data,
   output logic [IDX_W-1:0]  i_fill_idx,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_stall,
   output logic              d_fill_valid,
   output logic [DATA_W-1:0] d_fill_data,
   output logic [IDX_W-1:0]  d_fill_idx,
   output logic              d_done,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_data_valid,
   input  logic [DATA_W-1:0] mem_rdata
);

   if (MEM_LAT < 1 || (1 << IDX_W) != LINE_WORDS) begin : g_param_check
      $error("mem_arbiter: MEM_LAT must be >= 1 and LINE_WORDS a power of 2");
   end

   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 2 - 1);

   typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [IDX_W-1:0]  issue_cnt;
   logic [IDX_W-1:0]  recv_cnt;
   logic [IDX_W-1:0]  issue_nxt;
   logic              last_word;

   assign issue_nxt = issue_cnt + 1'b1;
   assign last_word = (recv_cnt == IDX_W'(LINE_WORDS - 1));

   // Return path is decoded so the last word and its done pulse share a cycle.
   assign i_fill_valid = (state == I_FILL) && mem_data_valid;
   assign d_fill_valid = (state == D_FILL) && mem_data_valid;
   assign i_fill_data  = i_fill_valid ? mem_rdata : '0;
   assign d_fill_data  = d_fill_valid ? mem_rdata : '0;
   assign i_fill_idx   = i_fill_valid ? recv_cnt : '0;
   assign d_fill_idx   = d_fill_valid ? recv_cnt : '0;
   assign i_done       = i_fill_valid && last_word;
   assign d_done       = (d_fill_valid && last_word) || (state == D_WRITE);
   assign i_stall      = i_req & ~i_done;
   assign d_stall      = d_req & ~d_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         base      <= '0;
         issue_cnt <= '0;
         recv_cnt  <= '0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               mem_en    <= 1'b0;
               mem_wr    <= 1'b0;
               issue_cnt <= '0;
               recv_cnt  <= '0;
               if (d_req && d_we) begin
                  state     <= D_WRITE;
                  mem_en    <= 1'b1;
                  mem_wr    <= 1'b1;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
               end else if (d_req) begin
                  state    <= D_FILL;
                  base     <= d_addr & ~LINE_MASK;
                  mem_en   <= 1'b1;
                  mem_addr <= d_addr & ~LINE_MASK;
               end else if (i_req) begin
                  state    <= I_FILL;
                  base     <= i_addr & ~LINE_MASK;
                  mem_en   <= 1'b1;
                  mem_addr <= i_addr & ~LINE_MASK;
               end
            end
            D_WRITE: begin
               state  <= IDLE;
               mem_en <= 1'b0;
               mem_wr <= 1'b0;
            end
            I_FILL, D_FILL: begin
               // issue_cnt names the word currently on mem_addr.
               if (mem_en) begin
                  if (issue_cnt == IDX_W'(LINE_WORDS - 1)) begin
                     mem_en <= 1'b0;
                  end else begin
                     issue_cnt <= issue_nxt;
                     mem_addr  <= base + ADDR_W'({issue_nxt, 1'b0});
                  end
               end
               if (mem_data_valid) begin
                  recv_cnt <= recv_cnt + 1'b1;
                  if (last_word) begin
                     state  <= IDLE;
                     mem_en <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
